// File: rtl/avalon_st_fifo.sv
// Avalon-ST FIFO: buffers one streaming source toward one sink, with
// ready/valid backpressure, a fill-level report and an in-line SOP/EOP
// framing checker. Output is show-ahead (head entry on out_* when out_valid).
// Optional feature: define AVST_FIFO_STORE_FWD_EN for store-and-forward mode
// (a beat is only presented once a whole packet is buffered, or the FIFO
// is full). Without it the FIFO is cut-through.
module avalon_st_fifo #(
  parameter  int DATA_W  = 64,
  parameter  int DEPTH   = 16,
  localparam int EMPTY_W = $clog2(DATA_W / 8),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               in_error,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_error,
  output logic [LVL_W-1:0]   fill_level,
  output logic               proto_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + EMPTY_W + 3;
  // Field offsets inside one stored entry {err, sop, eop, empty, data}
  localparam int EMP_LSB = DATA_W;
  localparam int EOP_BIT = DATA_W + EMPTY_W;
  localparam int SOP_BIT = DATA_W + EMPTY_W + 1;
  localparam int ERR_BIT = DATA_W + EMPTY_W + 2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_t;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             proto_err_q, proto_err_d;
  state_t           state_q, state_d;

  logic             full, empty, wr_en, rd_en, head_ok;
  logic [ENT_W-1:0] head;

  // Pointer-derived status: equal -> empty, MSB differs with equal index -> full
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

`ifdef AVST_FIFO_STORE_FWD_EN
  logic [LVL_W-1:0] pkt_cnt_q, pkt_cnt_d;

  // Only present data once a complete packet sits in the buffer; the full
  // term lets packets longer than the FIFO drain instead of deadlocking.
  always_comb begin
    head_ok = (pkt_cnt_q != '0) || full;
  end

  // Count buffered EOP beats: +1 on EOP write, -1 on EOP read
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({wr_en && in_endofpacket, rd_en && head[EOP_BIT]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Packet counter register
  always_ff @(posedge clk) begin
    if (reset) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end
`else
  // Cut-through: any buffered beat is presented immediately
  always_comb begin
    head_ok = 1'b1;
  end
`endif

  // Handshakes and pointer/ready next-state. in_ready is registered from the
  // next-cycle occupancy, so a read while full reopens the input a cycle later.
  always_comb begin
    out_valid  = !empty && head_ok;
    wr_en      = in_valid && in_ready_q;
    rd_en      = out_valid && out_ready;
    wr_ptr_d   = wr_ptr_q + (wr_en ? 1'b1 : 1'b0);
    rd_ptr_d   = rd_ptr_q + (rd_en ? 1'b1 : 1'b0);
    in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  // Storage write: the accepted beat lands at the write index
  always_comb begin
    mem_d = mem_q;
    if (wr_en)
      mem_d[wr_ptr_q[AW-1:0]] = {in_error, in_startofpacket, in_endofpacket,
                                 in_empty, in_data};
  end

  // Framing tracker: follows SOP/EOP of every accepted beat, flags stray
  // continuation beats and nested SOPs; the error stays set until reset.
  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    if (wr_en) begin
      if (state_q == S_IDLE && !in_startofpacket) proto_err_d = 1'b1;
      if (state_q == S_IN_PKT && in_startofpacket) proto_err_d = 1'b1;
      if (in_endofpacket)        state_d = S_IDLE;
      else if (in_startofpacket) state_d = S_IN_PKT;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b0;
      proto_err_q <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      proto_err_q <= proto_err_d;
      state_q     <= state_d;
    end
  end

  // Payload storage needs no reset; stale entries are never presented
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs: sideband forced to zero whenever nothing is presented
  always_comb begin
    in_ready          = in_ready_q;
    fill_level        = wr_ptr_q - rd_ptr_q;
    proto_err         = proto_err_q;
    out_data          = out_valid ? head[DATA_W-1:0] : '0;
    out_empty         = out_valid ? head[EMP_LSB +: EMPTY_W] : '0;
    out_endofpacket   = out_valid && head[EOP_BIT];
    out_startofpacket = out_valid && head[SOP_BIT];
    out_error         = out_valid && head[ERR_BIT];
  end

endmodule

// File: tb/tb_avalon_st_fifo.sv
// Self-checking bench for avalon_st_fifo: a constant vector table, directed
// corner sequences and a randomized run, all checked against a queue model.
module tb_avalon_st_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int EW    = 3;
  localparam int LW    = 5;
`ifdef AVST_FIFO_STORE_FWD_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_empty = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, out_sop, out_eop, out_err, proto_err;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic [LW-1:0] fill_level;

  always #5 clk = ~clk;

  avalon_st_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .in_data(in_data), .in_empty(in_empty), .in_error(in_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop),
    .out_data(out_data), .out_empty(out_empty), .out_error(out_err),
    .fill_level(fill_level), .proto_err(proto_err)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop, eop, err;
  } beat_t;

  beat_t q[$];
  bit    m_rdy = 1'b0, m_perr = 1'b0, m_inpkt = 1'b0;
  int    checks = 0, errors = 0;

  function automatic bit m_valid();
    int n;
    n = 0;
    foreach (q[i]) if (q[i].eop) n++;
    if (SF) return (q.size() != 0) && (n != 0 || q.size() == DEPTH);
    return q.size() != 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model across the edge, compare at negedge
  task automatic cyc(input bit rst_i, input bit v, input bit sop, input bit eop,
                     input logic [DW-1:0] d, input logic [EW-1:0] e,
                     input bit er, input bit ordy);
    bit    acc_w, acc_r;
    beat_t b;
    reset = rst_i; in_valid = v; in_sop = sop; in_eop = eop;
    in_data = d; in_empty = e; in_err = er; out_ready = ordy;
    acc_w = v && m_rdy && !rst_i;
    acc_r = m_valid() && ordy && !rst_i;
    @(posedge clk);
    if (rst_i) begin
      q.delete(); m_perr = 1'b0; m_inpkt = 1'b0; m_rdy = 1'b0;
    end else begin
      if (acc_r) void'(q.pop_front());
      if (acc_w) begin
        b.data = d; b.empty = e; b.sop = sop; b.eop = eop; b.err = er;
        q.push_back(b);
        if (!m_inpkt && !sop) m_perr = 1'b1;
        if (m_inpkt && sop)   m_perr = 1'b1;
        m_inpkt = eop ? 1'b0 : (sop ? 1'b1 : m_inpkt);
      end
      m_rdy = (q.size() != DEPTH);
    end
    @(negedge clk);
    chk("m_in_ready", 64'(in_ready), 64'(m_rdy));
    chk("m_out_valid", 64'(out_valid), 64'(m_valid()));
    chk("m_fill", 64'(fill_level), 64'(q.size()));
    chk("m_proto_err", 64'(proto_err), 64'(m_perr));
    if (m_valid() && out_valid) begin
      chk("m_data", out_data, q[0].data);
      chk("m_side", {59'd0, out_empty, out_sop, out_eop, out_err},
                    {59'd0, q[0].empty, q[0].sop, q[0].eop, q[0].err});
    end
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst, v, sop, eop;
    logic [15:0] d;
    logic [2:0]  e;
    bit ordy;
    bit x_rdy, x_val;
    int x_fill;
    bit x_perr;
    logic [15:0] x_d;
    logic [2:0]  x_e;
    bit x_sop;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int guard;
    logic [DW-1:0] d;
    bit pend, v, s, e;

    //          rst v sop eop d        e    ordy rdy val      fill perr x_d      x_e  x_sop
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 3'd0, 0,  0,  0,       0,   0,   16'h0000, 3'd0, 0};
    tbl[1]  = '{0, 0, 0, 0, 16'h0000, 3'd0, 0,  1,  0,       0,   0,   16'h0000, 3'd0, 0};
    tbl[2]  = '{0, 1, 1, 1, 16'h00A5, 3'd3, 0,  1,  1,       1,   0,   16'h00A5, 3'd3, 1};
    tbl[3]  = '{0, 0, 0, 0, 16'h0000, 3'd0, 1,  1,  0,       0,   0,   16'h0000, 3'd0, 0};
    tbl[4]  = '{0, 1, 0, 1, 16'h0011, 3'd5, 0,  1,  1,       1,   1,   16'h0011, 3'd5, 0};
    tbl[5]  = '{0, 0, 0, 0, 16'h0000, 3'd0, 1,  1,  0,       0,   1,   16'h0000, 3'd0, 0};
    tbl[6]  = '{1, 0, 0, 0, 16'h0000, 3'd0, 0,  0,  0,       0,   0,   16'h0000, 3'd0, 0};
    tbl[7]  = '{0, 0, 0, 0, 16'h0000, 3'd0, 0,  1,  0,       0,   0,   16'h0000, 3'd0, 0};
    tbl[8]  = '{0, 1, 1, 0, 16'h0021, 3'd1, 0,  1,  !SF,     1,   0,   16'h0021, 3'd1, 1};
    tbl[9]  = '{0, 1, 1, 0, 16'h0022, 3'd2, 0,  1,  !SF,     2,   1,   16'h0021, 3'd1, 1};
    tbl[10] = '{0, 1, 0, 1, 16'h0023, 3'd7, 0,  1,  1,       3,   1,   16'h0021, 3'd1, 1};
    tbl[11] = '{0, 0, 0, 0, 16'h0000, 3'd0, 1,  1,  1,       2,   1,   16'h0022, 3'd2, 1};
    tbl[12] = '{1, 0, 0, 0, 16'h0000, 3'd0, 0,  0,  0,       0,   0,   16'h0000, 3'd0, 0};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].sop, tbl[i].eop, DW'(tbl[i].d),
          tbl[i].e, 1'b0, tbl[i].ordy);
      chk($sformatf("tv%0d_rdy", i), 64'(in_ready), 64'(tbl[i].x_rdy));
      chk($sformatf("tv%0d_val", i), 64'(out_valid), 64'(tbl[i].x_val));
      chk($sformatf("tv%0d_fill", i), 64'(fill_level), 64'(tbl[i].x_fill));
      chk($sformatf("tv%0d_perr", i), 64'(proto_err), 64'(tbl[i].x_perr));
      if (tbl[i].x_val) begin
        chk($sformatf("tv%0d_data", i), out_data, 64'(tbl[i].x_d));
        chk($sformatf("tv%0d_empty", i), 64'(out_empty), 64'(tbl[i].x_e));
        chk($sformatf("tv%0d_sop", i), 64'(out_sop), 64'(tbl[i].x_sop));
      end else if (tbl[i].rst) begin
        chk($sformatf("tv%0d_side0", i),
            {out_data[59:0], out_empty, out_sop}, 64'd0);
      end
    end
    idle(1'b0);

    // Fill: 20 offered beats with the sink stalled, 16 land
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b1, i == 0, i == 19, DW'(100 + i), EW'(i), 1'b0, 1'b0);
    chk("full_fill", 64'(fill_level), 64'(DEPTH));
    chk("full_rdy", 64'(in_ready), 64'd0);
    chk("full_val", 64'(out_valid), 64'd1);
    idle(1'b1);
    chk("reopen_rdy", 64'(in_ready), 64'd1);
    chk("reopen_head", out_data, 64'd101);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("drained_fill", 64'(fill_level), 64'd0);

    // Streaming while full across several pointer wraps
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, DW'(i), '0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, DW'(DEPTH + i), '0, i[0], 1'b1);
    guard = 0;
    while (q.size() != 0 && guard < 100) begin idle(1'b1); guard++; end
    chk("wrap_drain", 64'(fill_level), 64'd0);

    // Reset mid-packet with five beats held and a framing error pending
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, i < 2, 1'b0, DW'(i), '0, 1'b0, 1'b0);
    chk("mid_fill5", 64'(fill_level), 64'd5);
    chk("mid_perr", 64'(proto_err), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_val", 64'(out_valid), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    idle(1'b0);

`ifdef AVST_FIFO_STORE_FWD_EN
    // Store-and-forward: held back until EOP, long packets drain when full
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, i == 0, 1'b0, DW'(i), '0, 1'b0, 1'b1);
    chk("sf_hold", 64'(out_valid), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, DW'(3), '0, 1'b0, 1'b1);
    chk("sf_release", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    guard = 0;
    for (int i = 0; i < 20; i++) begin
      while (!in_ready && guard < 100) begin idle(1'b1); guard++; end
      cyc(1'b0, 1'b1, i == 0, i == 19, DW'(200 + i), '0, 1'b0, 1'b1);
    end
    while (q.size() != 0 && guard < 200) begin idle(1'b1); guard++; end
    chk("sf_long_drain", 64'(fill_level), 64'd0);
`endif

    // Randomized traffic with upstream holding a stalled beat stable
    do_reset();
    pend = 1'b0; v = 1'b0; s = 1'b0; e = 1'b0; d = '0;
    for (int i = 0; i < 3000; i++) begin
      bit ordy;
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 3) == 0);
        e = ($urandom_range(0, 2) == 0);
        d = {$urandom, $urandom};
      end
      ordy = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      pend = v && !in_ready;
      cyc(1'b0, v, s, e, d, EW'($urandom), 1'(d[0]), ordy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
